// File: rtl/dotstar_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : dotstar_receiver
//  Description : DotStar (APA102-style) SPI packet receiver. Samples the
//                transmitter's sclk/mosi in the sys_clk domain, hunts for a
//                32-bit zero start frame, collects NUM_LEDS LED frames into
//                shadow slots, and publishes them atomically on a valid
//                all-ones end frame. Malformed packets or an idle sclk abort
//                the packet with a frame_error pulse.
//                Optional macro DOTSTAR_RX_BRIGHTNESS_EN adds the
//                led_bright_vector output carrying the 5-bit brightness field.
//  Revision    : 1.0 - initial release
// ============================================================================
module dotstar_receiver #(
   parameter int NUM_LEDS     = 8,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  mosi,
   output logic [NUM_LEDS*8-1:0] led_r_vector,
   output logic [NUM_LEDS*8-1:0] led_g_vector,
   output logic [NUM_LEDS*8-1:0] led_b_vector,
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
   output logic [NUM_LEDS*5-1:0] led_bright_vector,
`endif
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int C_LIDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int C_IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [C_LIDX_W-1:0] C_LAST_LED  = C_LIDX_W'(NUM_LEDS - 1);
   localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [C_IDLE_W-1:0] C_IDLE_MAX  = C_IDLE_W'(IDLE_TIMEOUT);

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_LED  = 2'd1,
      ST_END  = 2'd2
   } state_t;

   // Synchronizers and edge detector
   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic mosi_meta_q, mosi_sync_q;

   // Control state
   state_t                state_q,    state_d;
   logic [4:0]            zero_cnt_q, zero_cnt_d;
   logic [4:0]            bit_cnt_q,  bit_cnt_d;
   logic [C_LIDX_W-1:0]   led_idx_q,  led_idx_d;
   logic [31:0]           shift_q,    shift_d;
   logic                  word_vld_q, word_vld_d;
   logic [C_IDLE_W-1:0]   idle_q,     idle_d;
   logic                  done_q,     done_d;
   logic                  error_q,    error_d;

   // Shadow slots and published outputs
   logic [NUM_LEDS*8-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
   logic [NUM_LEDS*8-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
   logic [NUM_LEDS*5-1:0] sh_br_q, sh_br_d, out_br_q, out_br_d;
`endif

   logic w_strobe;
   logic w_timeout;

   // Bit strobe: rising edge of the synchronized sclk
   assign w_strobe  = sclk_sync_q & ~sclk_prev_q;
   // Idle limit is hit on the cycle the counter would reach IDLE_TIMEOUT
   assign w_timeout = ~w_strobe & (idle_q == C_IDLE_LAST);

   // Two-flop synchronizers for sclk and mosi, plus the edge-detect flop
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         sclk_meta_q <= sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   // State, counters, shift register, shadow slots and output registers
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_HUNT;
         zero_cnt_q <= '0;
         bit_cnt_q  <= '0;
         led_idx_q  <= '0;
         shift_q    <= '0;
         word_vld_q <= 1'b0;
         idle_q     <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         sh_r_q     <= '0;
         sh_g_q     <= '0;
         sh_b_q     <= '0;
         out_r_q    <= '0;
         out_g_q    <= '0;
         out_b_q    <= '0;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
         sh_br_q    <= '0;
         out_br_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         zero_cnt_q <= zero_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         led_idx_q  <= led_idx_d;
         shift_q    <= shift_d;
         word_vld_q <= word_vld_d;
         idle_q     <= idle_d;
         done_q     <= done_d;
         error_q    <= error_d;
         sh_r_q     <= sh_r_d;
         sh_g_q     <= sh_g_d;
         sh_b_q     <= sh_b_d;
         out_r_q    <= out_r_d;
         out_g_q    <= out_g_d;
         out_b_q    <= out_b_d;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
         sh_br_q    <= sh_br_d;
         out_br_q   <= out_br_d;
`endif
      end
   end

   // Next-state logic: bit assembly, start hunting, word decode, timeout
   always_comb begin
      state_d    = state_q;
      zero_cnt_d = zero_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      led_idx_d  = led_idx_q;
      shift_d    = shift_q;
      word_vld_d = 1'b0;
      idle_d     = idle_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      sh_r_d     = sh_r_q;
      sh_g_d     = sh_g_q;
      sh_b_d     = sh_b_q;
      out_r_d    = out_r_q;
      out_g_d    = out_g_q;
      out_b_d    = out_b_q;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      sh_br_d    = sh_br_q;
      out_br_d   = out_br_q;
`endif

      // Idle counter saturates so a stalled link reports only once
      if (w_strobe) begin
         idle_d = '0;
      end else if (idle_q != C_IDLE_MAX) begin
         idle_d = idle_q + 1'b1;
      end

      if (w_strobe) begin
         shift_d = {shift_q[30:0], mosi_sync_q};
      end

      case (state_q)
         ST_HUNT: begin
            // Word alignment is only meaningful once a start frame is seen
            bit_cnt_d = '0;
            led_idx_d = '0;
            if (w_timeout) begin
               zero_cnt_d = '0;
            end else if (w_strobe) begin
               if (mosi_sync_q) begin
                  zero_cnt_d = '0;
               end else if (zero_cnt_q == 5'd31) begin
                  zero_cnt_d = '0;
                  state_d    = ST_LED;
               end else begin
                  zero_cnt_d = zero_cnt_q + 5'd1;
               end
            end
         end

         ST_LED, ST_END: begin
            zero_cnt_d = '0;
            if (w_timeout) begin
               error_d = 1'b1;
               state_d = ST_HUNT;
            end else begin
               if (w_strobe) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd31) begin
                     word_vld_d = 1'b1;
                  end
               end
               if (word_vld_q) begin
                  if (state_q == ST_LED) begin
                     if ((led_idx_q == '0) && (shift_q == 32'h0)) begin
                        // Extra start word before the first LED frame
                        state_d = ST_LED;
                     end else if (shift_q[31:29] == 3'b111) begin
                        sh_r_d[led_idx_q*8 +: 8] = shift_q[7:0];
                        sh_g_d[led_idx_q*8 +: 8] = shift_q[15:8];
                        sh_b_d[led_idx_q*8 +: 8] = shift_q[23:16];
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
                        sh_br_d[led_idx_q*5 +: 5] = shift_q[28:24];
`endif
                        led_idx_d = led_idx_q + 1'b1;
                        if (led_idx_q == C_LAST_LED) begin
                           state_d = ST_END;
                        end
                     end else begin
                        error_d = 1'b1;
                        state_d = ST_HUNT;
                     end
                  end else begin
                     if (shift_q == 32'hFFFF_FFFF) begin
                        out_r_d = sh_r_q;
                        out_g_d = sh_g_q;
                        out_b_d = sh_b_q;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
                        out_br_d = sh_br_q;
`endif
                        done_d  = 1'b1;
                     end else begin
                        error_d = 1'b1;
                     end
                     state_d = ST_HUNT;
                  end
               end
            end
         end

         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   assign led_r_vector = out_r_q;
   assign led_g_vector = out_g_q;
   assign led_b_vector = out_b_q;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
   assign led_bright_vector = out_br_q;
`endif
   assign frame_done   = done_q;
   assign frame_error  = error_q;
   assign busy         = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_dotstar_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dotstar_receiver
//  Description : Directed self-checking bench for dotstar_receiver. Drives
//                sclk/mosi at 1/6 of sys_clk and checks decoded vectors,
//                pulse timing, abort paths and reset behaviour. When
//                DOTSTAR_RX_BRIGHTNESS_EN is defined the brightness output is
//                connected and checked as well.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dotstar_receiver;

   localparam int N = 8;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   logic sclk    = 1'b0;
   logic mosi    = 1'b0;
   logic [N*8-1:0] r_v, g_v, b_v;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
   logic [N*5-1:0] br_v;
   logic [N*5-1:0] exp_br;
`endif
   logic done, err, busy;

   int total = 0;
   int bad   = 0;
   int n_done = 0;
   int n_err  = 0;
   int n_both = 0;

   logic [31:0]    words [N];
   logic [N*8-1:0] exp_r, exp_g, exp_b;

   always #5 sys_clk = ~sys_clk;

   dotstar_receiver #(.NUM_LEDS(N), .IDLE_TIMEOUT(1024)) dut (
      .sys_clk           (sys_clk),
      .rst_n             (rst_n),
      .sclk              (sclk),
      .mosi              (mosi),
      .led_r_vector      (r_v),
      .led_g_vector      (g_v),
      .led_b_vector      (b_v),
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      .led_bright_vector (br_v),
`endif
      .frame_done        (done),
      .frame_error       (err),
      .busy              (busy)
   );

   // Pulse counters sampled on the falling edge, away from DUT updates
   always @(negedge sys_clk) begin
      if (done) n_done++;
      if (err) n_err++;
      if (done && err) n_both++;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns 3 sys_clk edges after the sclk rise
   task automatic send_bit(input logic b);
      mosi = b;
      sclk = 1'b0;
      repeat (3) @(negedge sys_clk);
      sclk = 1'b1;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic send_bits(input logic [31:0] w, input int nbits);
      for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   // kind 0: {FF, B=i, G=0x10+i, R=0x20+i}; kind 1: varied pattern, LED0 header 0xE5
   task automatic set_body(input int kind);
      for (int i = 0; i < N; i++) begin
         if (kind == 0)
            words[i] = {8'hFF, 8'(i), 8'(8'h10 + i), 8'(8'h20 + i)};
         else
            words[i] = {(i == 0) ? 8'hE5 : {3'b111, 5'(i * 3)},
                        8'(8'h5A + i * 17), 8'(8'hC3 - i * 9), 8'(i * 31)};
      end
   endtask

   // Expected outputs after a successful frame built from words[]
   task automatic commit_body();
      for (int i = 0; i < N; i++) begin
         exp_r[i*8 +: 8] = words[i][7:0];
         exp_g[i*8 +: 8] = words[i][15:8];
         exp_b[i*8 +: 8] = words[i][23:16];
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
         exp_br[i*5 +: 5] = words[i][28:24];
`endif
      end
   endtask

   task automatic send_packet(input int zeros);
      send_zeros(zeros);
      for (int i = 0; i < N; i++) send_bits(words[i], 32);
      send_bits(32'hFFFF_FFFF, 32);
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic check_outputs(input string tag);
      chk_eq({tag, "_r"}, r_v, exp_r);
      chk_eq({tag, "_g"}, g_v, exp_g);
      chk_eq({tag, "_b"}, b_v, exp_b);
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      chk_eq({tag, "_br"}, br_v, exp_br);
`endif
   endtask

   initial begin
      int base_d;
      int base_e;
      int seen;
      logic [7:0] byte_v;

      exp_r = '0; exp_g = '0; exp_b = '0;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      exp_br = '0;
`endif
      // Reset state
      repeat (3) @(negedge sys_clk);
      check_outputs("rst");
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      chk_eq("rst_err", err, 1'b0);
      rst_n = 1'b1;
      @(negedge sys_clk);

      // Valid packet with exact frame_done latency on the final sclk edge
      set_body(0);
      send_zeros(32);
      chk_eq("hunt_to_led_busy", busy, 1'b1);
      for (int i = 0; i < N; i++) send_bits(words[i], 32);
      send_bits(32'hFFFF_FFFF, 31);
      send_bit(1'b1);
      chk_eq("done_not_before_4", done, 1'b0);
      @(negedge sys_clk);
      chk_eq("done_at_4", done, 1'b1);
      @(negedge sys_clk);
      chk_eq("done_one_cycle", done, 1'b0);
      chk_eq("idle_after_done", busy, 1'b0);
      commit_body();
      check_outputs("pkt0");
      byte_v = r_v[7:0];
      chk_eq("r0_hand", byte_v, 8'h20);
      byte_v = b_v[63:56];
      chk_eq("b7_hand", byte_v, 8'h07);
      chk_eq("pkt0_ndone", n_done, 1);
      chk_eq("pkt0_nerr", n_err, 0);

      // Different body replaces the outputs
      set_body(1);
      send_packet(32);
      commit_body();
      check_outputs("pkt1");
      chk_eq("pkt1_ndone", n_done, 2);
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      byte_v = {3'b000, br_v[4:0]};
      chk_eq("bright0", byte_v, 8'd5);
`endif

      // 64 leading zeros: the extra start word is absorbed
      set_body(0);
      send_packet(64);
      commit_body();
      check_outputs("pkt64");
      byte_v = r_v[7:0];
      chk_eq("pkt64_r0", byte_v, 8'h20);
      chk_eq("pkt64_ndone", n_done, 3);
      chk_eq("pkt64_nerr", n_err, 0);

      // LED 3 with a bad header aborts four cycles after its last bit
      set_body(1);
      base_d = n_done;
      send_zeros(32);
      for (int i = 0; i < 3; i++) send_bits(words[i], 32);
      send_bits(32'h5F12_3456, 32);
      chk_eq("hdr_err_not_before_4", err, 1'b0);
      @(negedge sys_clk);
      chk_eq("hdr_err_at_4", err, 1'b1);
      chk_eq("hdr_err_busy", busy, 1'b0);
      @(negedge sys_clk);
      chk_eq("hdr_err_one_cycle", err, 1'b0);
      check_outputs("hdr_err_hold");
      chk_eq("hdr_err_ndone", n_done, base_d);

      // Idle in HUNT raises nothing
      base_e = n_err;
      repeat (1100) @(negedge sys_clk);
      chk_eq("hunt_idle_nerr", n_err, base_e);

      // sclk stalls after 100 bits: abort when the idle count hits 1024
      send_zeros(32);
      send_bits(words[0], 32);
      send_bits(words[1], 32);
      send_bits(words[2], 4);
      chk_eq("stall_busy", busy, 1'b1);
      seen = 0;
      for (int k = 1; k <= 1100; k++) begin
         @(negedge sys_clk);
         if (err && seen == 0) seen = k;
      end
      chk_eq("stall_err_cycle", seen, 1024);
      chk_eq("stall_nerr", n_err, base_e + 1);
      chk_eq("stall_busy_after", busy, 1'b0);
      check_outputs("stall_hold");
      send_packet(32);
      commit_body();
      check_outputs("after_stall");
      chk_eq("after_stall_ndone", n_done, base_d + 1);

      // Reset in the middle of LED 5 discards everything silently
      set_body(0);
      base_d = n_done;
      base_e = n_err;
      send_zeros(32);
      for (int i = 0; i < 5; i++) send_bits(words[i], 32);
      send_bits(words[5], 10);
      rst_n = 1'b0;
      sclk  = 1'b0;
      mosi  = 1'b0;
      repeat (2) @(negedge sys_clk);
      exp_r = '0; exp_g = '0; exp_b = '0;
`ifdef DOTSTAR_RX_BRIGHTNESS_EN
      exp_br = '0;
`endif
      check_outputs("midrst");
      chk_eq("midrst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge sys_clk);
      chk_eq("midrst_ndone", n_done, base_d);
      chk_eq("midrst_nerr", n_err, base_e);
      send_packet(32);
      commit_body();
      check_outputs("after_rst");
      chk_eq("after_rst_ndone", n_done, base_d + 1);
      chk_eq("after_rst_nerr", n_err, base_e);

      chk_eq("never_both", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
